// File: rtl/x_stage_multdiv_pkg.sv
// rtl/x_stage_multdiv_pkg.sv - shared types and constants for the execute-stage mult/div unit
//
// Purpose: FSM state encoding, operation select, default width and the
// exception codes that the status-register write path uses.
// Ports: none (package).
package x_stage_multdiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Status-register cause codes for multiply overflow / divide exceptions.
  localparam logic [3:0] MUL_EXC = 4'd4;
  localparam logic [3:0] DIV_EXC = 4'd5;

endpackage

// File: rtl/multdiv_datapath.sv
// rtl/multdiv_datapath.sv - Booth multiplier and non-restoring divider datapath
//
// Purpose: operand capture, one radix-2 Booth or non-restoring divide
// iteration per step, and combinational result/exception fix-up.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   load                capture operands and op, initialise accumulators
//   step                perform one iteration of the captured op
//   op_sel              operation to capture on load
//   operand_a/b         multiplicand/dividend, multiplier/divisor
//   result, exception   final value, valid once WIDTH steps have run
module multdiv_datapath
  import x_stage_multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  op_e              op_sel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  op_e              op_q;
  // Booth accumulator: {high word, low word/multiplier, q(-1)}.
  logic [2*WIDTH:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  // Divider: signed partial remainder, dividend/quotient shifter, divisor magnitude.
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic             bzero_q;
  logic             ovf_q;

  logic [WIDTH:0]   booth_sum;
  logic [2*WIDTH:0] acc_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // The add/sub is done one bit wider than the high word so that
  // subtracting the most-negative multiplicand cannot wrap; the arithmetic
  // shift then drops that extra bit back into the register.
  always_comb begin
    booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    case (acc_q[1:0])
      2'b01:   booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]} + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]} - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    endcase
    acc_d = {booth_sum, acc_q[WIDTH:1]};
  end

  // Non-restoring: subtract while the remainder is non-negative, add back
  // otherwise; each quotient bit is the inverted sign of the new remainder.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_d     = rem_q[WIDTH] ? rem_shift + {1'b0, dvs_q} : rem_shift - {1'b0, dvs_q};
    quo_d     = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= OP_MUL;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      op_q    <= op_sel;
      acc_q   <= {{WIDTH{1'b0}}, operand_b, 1'b0};
      mcand_q <= operand_a;
      rem_q   <= '0;
      quo_q   <= abs_a;
      dvs_q   <= abs_b;
      neg_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      bzero_q <= (operand_b == '0);
      ovf_q   <= (operand_a == MOST_NEG) && (operand_b == {WIDTH{1'b1}});
    end else if (step) begin
      if (op_q == OP_MUL) begin
        acc_q <= acc_d;
      end else begin
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
    end
  end

  assign prod_hi = acc_q[2*WIDTH:WIDTH+1];
  assign prod_lo = acc_q[WIDTH:1];

  always_comb begin
    result    = '0;
    exception = 1'b0;
    if (op_q == OP_MUL) begin
      result    = prod_lo;
      exception = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
    end else if (bzero_q) begin
      result    = '0;
      exception = 1'b1;
    end else begin
      // Negating 2^(WIDTH-1) wraps to MOST_NEG, which is the required
      // saturated-looking answer for MOST_NEG / -1.
      result    = neg_q ? -quo_q : quo_q;
      exception = ovf_q;
    end
  end

endmodule

// File: rtl/x_stage_multdiv.sv
// rtl/x_stage_multdiv.sv - iterative signed multiply/divide unit in the execute stage
//
// Purpose: sequences a WIDTH-cycle multiply or divide, stalling the
// upstream pipeline, and presents a one-cycle result pulse.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   ctrl_mult, ctrl_div       decoded op from the decode/execute latch
//   data_operandA/B           operands from the decode/execute latch
//   stall                     holds fetch/decode and the D/X latch
//   data_resultRDY            one-cycle result-valid pulse
//   data_result               product low word or quotient
//   data_exception            overflow or divide-by-zero, qualified by RDY
module x_stage_multdiv
  import x_stage_multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             stall,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             step;
  op_e              op_sel;
  logic [WIDTH-1:0] dp_result;
  logic             dp_exception;
  logic [WIDTH-1:0] result_q;
  logic             exception_q;

  // Multiply wins when both controls are raised.
  assign op_sel = ctrl_mult ? OP_MUL : OP_DIV;

  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    load           = 1'b0;
    step           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_q)
      IDLE: begin
        stall = ctrl_mult | ctrl_div;
        if (ctrl_mult | ctrl_div) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        step  = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        // ctrl_* still shows the retiring instruction here, so it is ignored.
        data_resultRDY = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      exception_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
      if (state_q == DONE) begin
        result_q    <= dp_result;
        exception_q <= dp_exception;
      end
    end
  end

  // Outside DONE the outputs hold whatever the last DONE presented.
  assign data_result    = (state_q == DONE) ? dp_result : result_q;
  assign data_exception = (state_q == DONE) ? dp_exception : exception_q;

  multdiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .op_sel    (op_sel),
    .operand_a (data_operandA),
    .operand_b (data_operandB),
    .result    (dp_result),
    .exception (dp_exception)
  );

endmodule

// File: tb/tb_x_stage_multdiv.sv
// tb/tb_x_stage_multdiv.sv - self-checking bench for x_stage_multdiv
module tb_x_stage_multdiv;
  import x_stage_multdiv_pkg::*;

  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        stall;
  logic        data_resultRDY;
  logic [31:0] data_result;
  logic        data_exception;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  x_stage_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .stall          (stall),
    .data_resultRDY (data_resultRDY),
    .data_result    (data_result),
    .data_exception (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: 64-bit signed product, SV signed division (truncates toward zero).
  function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q;
    if (m) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {(p[63:32] != {32{p[31]}}), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic do_op(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee,
                       input bit scramble, output int rdy_cyc);
    exp_t e;
    int   k;
    bit   got;
    bit   stall_ok;
    e.res = er;
    e.exc = ee;
    sb.push_back(e);
    @(negedge clock);
    ctrl_mult = m; ctrl_div = d; data_operandA = a; data_operandB = b;
    #1;
    stall_ok = (stall === 1'b1) && (data_resultRDY === 1'b0);
    k = 0; got = 0;
    while (!got && k < 100) begin
      @(negedge clock);
      k++;
      if (data_resultRDY === 1'b1) begin
        got = 1;
        if (stall !== 1'b0) stall_ok = 0;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        if (scramble) begin
          data_operandA = $urandom;
          data_operandB = $urandom;
        end
      end
    end
    rdy_cyc = cyc;
    check({tag, " latency"}, 64'(k), 64'd33);
    check({tag, " stall"}, {63'd0, stall_ok}, 64'd1);
    e = sb.pop_front();
    if (got) begin
      check({tag, " result"}, {32'd0, data_result}, {32'd0, e.res});
      check({tag, " exc"}, {63'd0, data_exception}, {63'd0, e.exc});
    end
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
  endtask

  initial begin
    int          t1;
    int          t2;
    int          tr;
    bit          seen;
    logic        rm;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] mv;

    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset state", {62'd0, dut.state_q}, {62'd0, IDLE});
    check("reset cnt", {58'd0, dut.cnt_q}, 64'd0);
    check("reset rdy", {63'd0, data_resultRDY}, 64'd0);
    check("reset result", {32'd0, data_result}, 64'd0);
    check("reset exc", {63'd0, data_exception}, 64'd0);
    check("reset stall", {63'd0, stall}, 64'd0);
    reset = 1'b0;

    do_op("mul 7x6", 1, 0, 32'd7, 32'd6, 32'd42, 0, 0, t1);
    do_op("mul -3x5", 1, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0, 0, t1);
    do_op("mul ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 0, t1);
    do_op("mul minxmin", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 0, t1);
    do_op("mul minx-1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, t1);
    do_op("div 100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 0, t1);
    do_op("div -100/7", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0, t1);
    do_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'd0, 1, 0, t1);
    do_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, t1);
    do_op("div min/min", 0, 1, 32'h8000_0000, 32'h8000_0000, 32'd1, 0, 0, t1);

    // Reset in the middle of a multiply.
    @(negedge clock);
    ctrl_mult = 1'b1; data_operandA = 32'd11; data_operandB = 32'd13;
    repeat (10) @(negedge clock);
    reset = 1'b1; ctrl_mult = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("abort state", {62'd0, dut.state_q}, {62'd0, IDLE});
    check("abort stall", {63'd0, stall}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) seen = 1;
    end
    check("abort no rdy", {63'd0, seen}, 64'd0);
    do_op("post-reset mul", 1, 0, 32'd11, 32'd13, 32'd143, 0, 0, t1);

    // Back-to-back with operands scrambled during BUSY.
    do_op("b2b mul", 1, 0, 32'd1234, 32'hFFFF_FF00, 32'hFFFB_2E00, 0, 1, t1);
    do_op("b2b div", 0, 1, 32'd1000, 32'd33, 32'd30, 0, 1, t2);
    check("b2b spacing", 64'(t2 - t1), 64'd34);
    do_op("both high", 1, 1, 32'd9, 32'd3, 32'd27, 0, 0, t1);

    for (int i = 0; i < 8; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i[0]) ? 32'($urandom_range(1, 300)) : $urandom);
      mv = model(rm, ra, rb);
      do_op($sformatf("rand%0d", i), rm, ~rm, ra, rb, mv[31:0], mv[32], 0, tr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_stage_multdiv.md
Name: x_stage_multdiv

Overview:
- Iterative signed multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline latch.
- Consumes operands A/B and the mul/div control decoded into that latch.
- Computes over WIDTH cycles, holding the pipeline via `stall`. Upstream latches use wren = ~stall.
- Presents a one-cycle result with an exception flag to the execute/memory latch.

Parameters:
- WIDTH, 32, operand/result width in bits; also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ctrl_mult  in  1  execute instruction is a signed multiply
- ctrl_div  in  1  execute instruction is a signed divide
- data_operandA  in  WIDTH  multiplicand / dividend (regA read from latch)
- data_operandB  in  WIDTH  multiplier / divisor (regB read from latch)
- stall  out  1  hold fetch/decode and the decode/execute latch
- data_resultRDY  out  1  result valid this cycle (one-cycle pulse)
- data_result  out  WIDTH  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero; valid with RDY

Behaviour:
- Reset state: IDLE.
  - stall = 0 whenever ctrl_mult/ctrl_div are low.
  - data_resultRDY = 0, data_result = 0, data_exception = 0, counter = 0.
- Reset has priority over every other event. Reset mid-BUSY aborts the operation: state goes to IDLE next cycle and no RDY pulse follows.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = ctrl_mult | ctrl_div, combinationally in the same cycle.
  - On the edge, if ctrl_mult or ctrl_div is high: latch A, B and op, clear the counter, and go to BUSY.
  - If both are high, mult wins.
- BUSY:
  - stall = 1. Performs one iteration per cycle and increments the counter.
  - When counter == WIDTH-1, goes to DONE on that edge.
- DONE:
  - stall = 0, data_resultRDY = 1, result and exception are driven.
  - Always goes to IDLE next cycle. ctrl_* are ignored in DONE because they belong to the same, now-retiring instruction.
- Latency: start edge plus WIDTH BUSY cycles, so RDY appears WIDTH+1 cycles after the first ctrl cycle. Back-to-back ops therefore take WIDTH+2 cycles each.
- Operand capture: operands are sampled only on the IDLE->BUSY edge. Later input changes have no effect.
- Multiply: radix-2 Booth, signed two's complement.
  - Result = low WIDTH bits of the 2*WIDTH product.
  - Exception = 1 when the high word is not the sign-extension of bit WIDTH-1 of the low word.
- Divide: signed non-restoring on magnitudes, quotient truncated toward zero; sign is applied at DONE, and the remainder is discarded.
  - B == 0: result = 0, exception = 1.
  - A == most-negative and B == -1: result = most-negative, exception = 1.
  - Otherwise exception = 0.
- Outputs outside DONE: data_result and data_exception hold their last DONE values. Only RDY qualifies them.
- Width rules: internal accumulator is 2*WIDTH+1 bits for Booth and WIDTH+1 bits for the divider remainder. All arithmetic is two's complement with no saturation.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - op select constants (OP_MUL, OP_DIV)
  - WIDTH default
  - exception code constants used later by the status-register write path (MUL_EXC=4, DIV_EXC=5)
- One sub-module, multdiv_datapath: the operand/accumulator shift registers, Booth add/sub, divider add/sub and final sign fix-up, driven by op, load and step enables.
- The FSM and counter stay in x_stage_multdiv. Pipeline-boundary storage reuses the existing `register` block.

Test Plan:
- Basic multiply: A=7, B=6, ctrl_mult pulse (held while stall). Expect stall=1 from cycle 0 through cycle 32, RDY only at cycle 33, result=42, exception=0.
- Signed multiply and overflow:
  - -3 × 5 -> 0xFFFFFFF1, exception=0.
  - 0x00010000 × 0x00010000 -> result 0x00000000, exception=1.
- Divide cases:
  - 100 / -7 -> 0xFFFFFFF2 (-14), exception=0.
  - -100 / 7 -> -14.
  - 5 / 0 -> result 0, exception=1.
  - 0x80000000 / -1 -> 0x80000000, exception=1.
- Reset mid-op: start mult, assert reset at cycle 10. Expect state IDLE next cycle, stall=0, no RDY in the following 40 cycles. A fresh op afterwards completes correctly.
- Back-to-back plus operand change:
  - Mul then div on consecutive instructions: second RDY exactly 34 cycles after the first.
  - Changing data_operandA/B during BUSY does not alter either result.
  - ctrl_mult and ctrl_div both high -> multiply performed.
